vector_mem_sequencer: RTL and testbench

//  Element-serial vector load/store engine; initiator-side counterpart of the vector register file.
//  VLD: fetches NELEM words from memory, then writes them to one vector register in a single write.
//  VST: reads one vector register in a single read, then streams its NELEM words to memory.

---
 rtl/vector_mem_sequencer_pkg.sv | 22 ++
 rtl/vector_mem_sequencer_addr_gen.sv | 48 ++++
 rtl/vector_mem_sequencer.sv | 118 +++++++++++
 tb/tb_vector_mem_sequencer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/vector_mem_sequencer_pkg.sv
// Shared types for the vector load/store sequencer: sizes, FSM states and
// pack/unpack helpers for the flat NELEM*DW register-file bus.
package vec_pkg;
  localparam int NELEM = 5;
  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int RW    = 4;
  localparam int CW    = $clog2(NELEM);

  typedef enum logic [2:0] {IDLE, RDV, ISSUE, WAITR, WB, FIN} state_e;

  // Element i lives at [i*DW +: DW], identical to the flat bus layout.
  typedef logic [NELEM-1:0][DW-1:0] vec_t;

  function automatic logic [NELEM*DW-1:0] pack_vec(input vec_t v);
    return v;
  endfunction

  function automatic vec_t unpack_vec(input logic [NELEM*DW-1:0] b);
    return b;
  endfunction
endpackage

// File: rtl/vector_mem_sequencer_addr_gen.sv
// Running element address and element counter for one vector command.
module vec_addr_gen
  import vec_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          load_i,
  input  logic          step_i,
  input  logic [AW-1:0] base_i,
  input  logic [AW-1:0] stride_i,
  output logic [AW-1:0] addr_o,
  output logic [CW-1:0] idx_o,
  output logic          last_o
);
  logic [AW-1:0] addr_q, addr_d, stride_q, stride_d;
  logic [CW-1:0] idx_q, idx_d;

  always_comb begin
    addr_d   = addr_q;
    stride_d = stride_q;
    idx_d    = idx_q;
    if (load_i) begin
      addr_d   = base_i;
      stride_d = stride_i;
      idx_d    = '0;
    end else if (step_i) begin
      // Wraps modulo 2^AW by construction.
      addr_d = addr_q + stride_q;
      idx_d  = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q   <= '0;
      stride_q <= '0;
      idx_q    <= '0;
    end else begin
      addr_q   <= addr_d;
      stride_q <= stride_d;
      idx_q    <= idx_d;
    end
  end

  assign addr_o = addr_q;
  assign idx_o  = idx_q;
  assign last_o = (idx_q == CW'(NELEM-1));
endmodule

// File: rtl/vector_mem_sequencer.sv
// Element-serial vector load/store engine between the control unit, the
// vector register file and the data-memory port.
module vector_mem_sequencer
  import vec_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                is_store,
  input  logic [RW-1:0]       vreg_idx,
  input  logic [AW-1:0]       base_addr,
  input  logic [AW-1:0]       stride,
  output logic                busy,
  output logic                done,
  output logic [RW-1:0]       vrf_ra,
  input  logic [NELEM*DW-1:0] vrf_rd,
  output logic                vrf_we,
  output logic [RW-1:0]       vrf_wa,
  output logic [NELEM*DW-1:0] vrf_wd,
  output logic                mem_req,
  output logic                mem_we,
  output logic [AW-1:0]       mem_addr,
  output logic [DW-1:0]       mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DW-1:0]       mem_rdata
);
  state_e        state_q, state_d;
  logic          store_q, store_d;
  logic [RW-1:0] vreg_q, vreg_d;
  vec_t          buf_q, buf_d;

  logic          accept, step, last;
  logic [AW-1:0] addr;
  logic [CW-1:0] idx;

  assign accept = (state_q == IDLE) && start;
  assign step   = ((state_q == ISSUE) && mem_gnt && store_q) ||
                  ((state_q == WAITR) && mem_rvalid);

  vec_addr_gen u_agen (
    .clk      (clk),
    .reset    (reset),
    .load_i   (accept),
    .step_i   (step),
    .base_i   (base_addr),
    .stride_i (stride),
    .addr_o   (addr),
    .idx_o    (idx),
    .last_o   (last)
  );

  // All outputs decode from registered state, so an async reset zeroes them at once.
  always_comb begin
    state_d   = state_q;
    store_d   = store_q;
    vreg_d    = vreg_q;
    buf_d     = buf_q;
    busy      = (state_q != IDLE);
    done      = 1'b0;
    vrf_ra    = '0;
    vrf_we    = 1'b0;
    vrf_wa    = '0;
    vrf_wd    = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      IDLE: if (start) begin
        store_d = is_store;
        vreg_d  = vreg_idx;
        state_d = is_store ? RDV : ISSUE;
      end
      RDV: begin
        vrf_ra  = vreg_q;
        buf_d   = unpack_vec(vrf_rd);
        state_d = ISSUE;
      end
      ISSUE: begin
        mem_req   = 1'b1;
        mem_we    = store_q;
        mem_addr  = addr;
        mem_wdata = store_q ? buf_q[idx] : '0;
        if (mem_gnt) state_d = store_q ? (last ? FIN : ISSUE) : WAITR;
      end
      WAITR: if (mem_rvalid) begin
        buf_d[idx] = mem_rdata;
        state_d    = last ? WB : ISSUE;
      end
      WB: begin
        vrf_we  = 1'b1;
        vrf_wa  = vreg_q;
        vrf_wd  = pack_vec(buf_q);
        state_d = FIN;
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      store_q <= 1'b0;
      vreg_q  <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      store_q <= store_d;
      vreg_q  <= vreg_d;
      buf_q   <= buf_d;
    end
  end
endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Directed bench for vector_mem_sequencer with an in-line memory responder.
module tb_vector_mem_sequencer;
  import vec_pkg::*;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                start = 1'b0, is_store = 1'b0;
  logic [RW-1:0]       vreg_idx = '0;
  logic [AW-1:0]       base_addr = '0, stride = '0;
  logic                busy, done, vrf_we, mem_req, mem_we;
  logic [RW-1:0]       vrf_ra, vrf_wa;
  logic [NELEM*DW-1:0] vrf_rd, vrf_wd;
  logic [AW-1:0]       mem_addr;
  logic [DW-1:0]       mem_wdata;
  logic                mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [DW-1:0]       mem_rdata = '0;

  always #5 clk = ~clk;

  logic [NELEM*DW-1:0] rf [16];
  assign vrf_rd = rf[vrf_ra];

  vector_mem_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store),
    .vreg_idx(vreg_idx), .base_addr(base_addr), .stride(stride),
    .busy(busy), .done(done), .vrf_ra(vrf_ra), .vrf_rd(vrf_rd),
    .vrf_we(vrf_we), .vrf_wa(vrf_wa), .vrf_wd(vrf_wd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  int total = 0, bad = 0;
  logic [AW-1:0] qa[$];
  logic [DW-1:0] qd[$];
  int nwe, nmw, ndone, done_cyc, cyc, nrd;
  logic [RW-1:0] wa_log;
  logic [NELEM*DW-1:0] wd_log;
  logic pend_rv;
  logic [DW-1:0] pend_data;
  logic [DW-1:0] rtab [NELEM];
  int stall_elem, stall_left, stall_cmp;
  logic stall_seen, spur_en;
  logic [AW-1:0] stall_addr;
  logic [DW-1:0] stall_wd;
  logic [AW-1:0] exp_a [NELEM];

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic clear();
    qa.delete(); qd.delete();
    nwe = 0; nmw = 0; ndone = 0; done_cyc = -1; cyc = 0; nrd = 0;
    pend_rv = 1'b0; stall_elem = -1; stall_left = 0; stall_cmp = 0;
    stall_seen = 1'b0; spur_en = 1'b0; wa_log = '0; wd_log = '0;
  endtask

  // One clock: drive memory inputs for the current cycle, log outputs, advance to next negedge.
  task automatic tick();
    mem_rvalid = pend_rv;
    mem_rdata  = pend_data;
    pend_rv    = 1'b0;
    mem_gnt    = 1'b0;
    if (mem_req) begin
      if (qa.size() == stall_elem && stall_left > 0) begin
        if (!stall_seen) begin
          stall_addr = mem_addr; stall_wd = mem_wdata; stall_seen = 1'b1;
        end else begin
          chk("stall_addr", 160'(mem_addr), 160'(stall_addr));
          chk("stall_wdata", 160'(mem_wdata), 160'(stall_wd));
          stall_cmp++;
        end
        stall_left--;
        if (spur_en) begin mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0; end
      end else begin
        mem_gnt = 1'b1;
        qa.push_back(mem_addr);
        qd.push_back(mem_wdata);
        if (!mem_we) begin
          pend_rv = 1'b1; pend_data = rtab[nrd % NELEM]; nrd++;
        end
      end
    end
    if (vrf_we) begin nwe++; wa_log = vrf_wa; wd_log = vrf_wd; end
    if (mem_we) nmw++;
    if (done) begin ndone++; done_cyc = cyc; end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input logic st, input logic [RW-1:0] idx, input logic [AW-1:0] base,
                     input logic [AW-1:0] strd, input logic dbl);
    is_store = st; vreg_idx = idx; base_addr = base; stride = strd; start = 1'b1;
    tick();
    start = 1'b0;
    // Scramble command inputs to prove they were latched.
    is_store = ~st; vreg_idx = ~idx; base_addr = 32'hDEAD_0000; stride = 32'h1;
    for (int k = 0; k < 80 && ndone == 0; k++) begin
      if (dbl && k == 2) begin start = 1'b1; is_store = 1'b1; vreg_idx = 4'd9; end
      tick();
      start = 1'b0;
    end
    repeat (3) tick();
  endtask

  task automatic chk_addrs(input string tag);
    chk({tag, "_nreq"}, 160'(qa.size()), 160'(NELEM));
    for (int e = 0; e < NELEM && e < qa.size(); e++)
      chk({tag, "_addr"}, 160'(qa[e]), 160'(exp_a[e]));
  endtask

  initial begin
    for (int r = 0; r < 16; r++) rf[r] = '0;
    rf[7] = {32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
    clear();
    #1;
    chk("reset_outs", 160'({busy, done, vrf_we, mem_req, mem_we, vrf_ra, vrf_wa, mem_addr, mem_wdata}), 160'(0));
    chk("reset_wd", 160'(vrf_wd), 160'(0));
    @(negedge clk); @(negedge clk);
    reset = 1'b1;

    // 1: VLD v3 from 0x100 stride 4
    clear();
    for (int e = 0; e < NELEM; e++) rtab[e] = 32'hA0 + 32'(e);
    exp_a = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110};
    run(1'b0, 4'd3, 32'h100, 32'd4, 1'b0);
    chk_addrs("t1");
    chk("t1_nwe", 160'(nwe), 160'(1));
    chk("t1_wa", 160'(wa_log), 160'(3));
    chk("t1_wd", 160'(wd_log), 160'h000000A4_000000A3_000000A2_000000A1_000000A0);
    chk("t1_done_cyc", 160'(done_cyc), 160'(12));
    chk("t1_ndone", 160'(ndone), 160'(1));
    chk("t1_no_mem_we", 160'(nmw), 160'(0));

    // 2: VST v7 to 0x200 stride 8
    clear();
    exp_a = '{32'h200, 32'h208, 32'h210, 32'h218, 32'h220};
    run(1'b1, 4'd7, 32'h200, 32'd8, 1'b0);
    chk_addrs("t2");
    for (int e = 0; e < NELEM && e < qd.size(); e++) chk("t2_wdata", 160'(qd[e]), 160'(e + 1));
    chk("t2_nmw", 160'(nmw), 160'(5));
    chk("t2_nwe", 160'(nwe), 160'(0));
    chk("t2_done_cyc", 160'(done_cyc), 160'(7));

    // 3: same store, gnt withheld 3 cycles on element 2
    clear();
    stall_elem = 2; stall_left = 3;
    run(1'b1, 4'd7, 32'h200, 32'd8, 1'b0);
    chk_addrs("t3");
    for (int e = 0; e < NELEM && e < qd.size(); e++) chk("t3_wdata", 160'(qd[e]), 160'(e + 1));
    chk("t3_stall_addr", 160'(stall_addr), 160'(32'h210));
    chk("t3_stall_wd", 160'(stall_wd), 160'(3));
    chk("t3_stall_cmp", 160'(stall_cmp), 160'(2));
    chk("t3_nwe", 160'(nwe), 160'(0));
    chk("t3_done_cyc", 160'(done_cyc), 160'(10));

    // 4: VLD with address wrap-around
    clear();
    for (int e = 0; e < NELEM; e++) rtab[e] = 32'h1100 + 32'(e);
    exp_a = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8};
    run(1'b0, 4'd1, 32'hFFFF_FFF8, 32'd4, 1'b0);
    chk_addrs("t4");
    chk("t4_wa", 160'(wa_log), 160'(1));
    chk("t4_wd", 160'(wd_log), 160'h00001104_00001103_00001102_00001101_00001100);
    chk("t4_done_cyc", 160'(done_cyc), 160'(12));

    // 5: stride 0, second start while busy, spurious rvalid in ISSUE
    clear();
    for (int e = 0; e < NELEM; e++) rtab[e] = 32'h5000 + 32'(e * 3);
    stall_elem = 1; stall_left = 2; spur_en = 1'b1;
    exp_a = '{32'h40, 32'h40, 32'h40, 32'h40, 32'h40};
    run(1'b0, 4'd2, 32'h40, 32'd0, 1'b1);
    chk_addrs("t5");
    chk("t5_ndone", 160'(ndone), 160'(1));
    chk("t5_nwe", 160'(nwe), 160'(1));
    chk("t5_wa", 160'(wa_log), 160'(2));
    chk("t5_wd", 160'(wd_log), 160'h0000500C_00005009_00005006_00005003_00005000);
    chk("t5_nmw", 160'(nmw), 160'(0));
    chk("t5_done_cyc", 160'(done_cyc), 160'(14));

    // 6: reset while waiting for element 3's read data
    clear();
    for (int e = 0; e < NELEM; e++) rtab[e] = 32'h77 + 32'(e);
    is_store = 1'b0; vreg_idx = 4'd5; base_addr = 32'h300; stride = 32'd4; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 40 && qa.size() < 4; k++) tick();
    chk("t6_busy_pre", 160'(busy), 160'(1));
    reset = 1'b0;
    #1;
    chk("t6_rst_outs", 160'({busy, done, vrf_we, mem_req, mem_we, vrf_ra, vrf_wa, mem_addr, mem_wdata}), 160'(0));
    chk("t6_rst_wd", 160'(vrf_wd), 160'(0));
    pend_rv = 1'b0;
    repeat (3) tick();
    chk("t6_nreq", 160'(qa.size()), 160'(4));
    chk("t6_nwe", 160'(nwe), 160'(0));
    chk("t6_ndone", 160'(ndone), 160'(0));
    reset = 1'b1;
    clear();
    exp_a = '{32'h500, 32'h510, 32'h520, 32'h530, 32'h540};
    run(1'b1, 4'd7, 32'h500, 32'h10, 1'b0);
    chk_addrs("t6b");
    for (int e = 0; e < NELEM && e < qd.size(); e++) chk("t6b_wdata", 160'(qd[e]), 160'(e + 1));
    chk("t6b_done_cyc", 160'(done_cyc), 160'(7));
    chk("t6b_nwe", 160'(nwe), 160'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
